// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the sequential double-dabble converter.
// Macro BIN2BCD_BLANK_EN (used by the top) selects leading-zero blanking.
package bin2bcd_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BLANK_CODE  = 4'hF;

  // Decimal digits needed to hold 2^w-1.
  function automatic int bcd_digits(input int w);
    longint unsigned lim;
    int n;
    lim = (64'd1 << w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (lim > 64'd9) begin
        lim = lim / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 when the digit is >= 5.
// Ports: d (4-bit digit in), q (corrected digit out).
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= ADD3_THRESH) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// Ports: clk, rst (async high), in_valid/in_ready/bin input handshake,
// out_valid/out_ready/bcd result handshake, busy while shifting.
// Macro BIN2BCD_BLANK_EN: replace leading zero digits with 4'hF.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  generate
    if (DIGITS < bcd_digits(W)) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS too small for W");
    end
  endgenerate

  logic [1:0]    state;
  logic [W-1:0]  binreg;
  logic [BW-1:0] digits;
  logic [BW-1:0] adj;
  logic [BW-1:0] nxt_digits;
  logic [BW-1:0] res;
  logic [BW-1:0] bcd_q;
  logic [CW-1:0] cnt;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
        .d (digits[4*i +: 4]),
        .q (adj[4*i +: 4])
      );
    end
  endgenerate

  // Top bit of the corrected digits falls off; it is always zero
  // because DIGITS covers the full input range.
  assign nxt_digits = {adj[BW-2:0], binreg[W-1]};

  always_comb begin
`ifdef BIN2BCD_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    res = nxt_digits;
`ifdef BIN2BCD_BLANK_EN
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (res[4*i +: 4] == 4'd0)) begin
        res[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      binreg <= '0;
      digits <= '0;
      cnt    <= '0;
      bcd_q  <= '0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          if (in_valid) begin
            binreg <= bin;
            digits <= '0;
            cnt    <= CW'(W);
            state  <= S_SHIFT;
          end
        end
        (state == S_SHIFT): begin
          digits <= nxt_digits;
          binreg <= {binreg[W-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
          // Only the finished value reaches bcd.
          if (cnt == CW'(1)) begin
            bcd_q <= res;
            state <= S_DONE;
          end
        end
        (state == S_DONE): begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state == S_SHIFT);
  assign out_valid = (state == S_DONE);
  assign bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and sweep checks for bin2bcd_seq.
// Honours BIN2BCD_BLANK_EN for expected values.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] bcd;
  logic        busy;

  int checks   = 0;
  int failures = 0;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [11:0] E15 = 12'hF15;
  localparam logic [11:0] E0  = 12'hFF0;
  localparam logic [11:0] E42 = 12'hF42;
  localparam logic [11:0] E99 = 12'hF99;
`else
  localparam logic [11:0] E15 = 12'h015;
  localparam logic [11:0] E0  = 12'h000;
  localparam logic [11:0] E42 = 12'h042;
  localparam logic [11:0] E99 = 12'h099;
`endif

  bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] ref_bcd(input int v);
    logic [3:0] d2, d1, d0;
    d2 = 4'(v / 100);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
`ifdef BIN2BCD_BLANK_EN
    if (d2 == 4'd0) begin
      d2 = 4'hF;
      if (d1 == 4'd0) d1 = 4'hF;
    end
`endif
    return {d2, d1, d0};
  endfunction

  // Stimulus only: accept v, wait for out_valid, report latency.
  task automatic do_conv(input logic [7:0] v, input logic hold_rdy,
                         output int lat, output logic [11:0] res,
                         output logic saw_rdy);
    int g;
    @(negedge clk);
    bin = v;
    in_valid = 1'b1;
    out_ready = hold_rdy;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    saw_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) saw_rdy = 1'b1;
      @(negedge clk);
      lat++;
    end
    res = bcd;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    bin = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 100",
               {in_ready, out_valid, busy});
    end
    checks++;
    if (bcd !== 12'h000) begin
      failures++;
      $display("FAIL reset_bcd: got %h expected 000", bcd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    logic [11:0] r;
    logic sr;
    do_conv(8'd15, 1'b0, lat, r, sr);
    checks++;
    if (lat !== 8) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    checks++;
    if (r !== E15) begin
      failures++;
      $display("FAIL basic_bcd: got %h expected %h", r, E15);
    end
    checks++;
    if (sr !== 1'b0) begin
      failures++;
      $display("FAIL basic_in_ready_busy: got %b expected 0", sr);
    end
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL basic_release: got %b expected 01",
               {out_valid, in_ready});
    end
`ifndef BIN2BCD_BLANK_EN
    checks++;
    if (bcd !== E15) begin
      failures++;
      $display("FAIL basic_hold: got %h expected %h", bcd, E15);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    int g;
    logic sr;
    @(negedge clk);
    bin = 8'd255;
    in_valid = 1'b1;
    out_ready = 1'b0;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    bin = 8'd225;
    lat = 0;
    sr = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) sr = 1'b1;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8 || bcd !== 12'h255) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d bcd=%h expected lat=8 bcd=255",
               lat, bcd);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({sr, in_ready, out_valid} !== 3'b001 || bcd !== 12'h255) begin
      failures++;
      $display("FAIL b2b_hold: got %b bcd=%h expected 001 bcd=255",
               {sr, in_ready, out_valid}, bcd);
    end
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_release: got %b expected 01",
               {out_valid, in_ready});
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_second_accept: got %b expected 10",
               {busy, in_ready});
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 8 || bcd !== 12'h225) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d bcd=%h expected lat=8 bcd=225",
               lat, bcd);
    end
    release_out();
  endtask

  task automatic test_zero_100();
    int lat;
    logic [11:0] r;
    logic sr;
    do_conv(8'd0, 1'b1, lat, r, sr);
    checks++;
    if (lat !== 8 || r !== E0) begin
      failures++;
      $display("FAIL zero: got lat=%0d bcd=%h expected lat=8 bcd=%h",
               lat, r, E0);
    end
    release_out();
    do_conv(8'd100, 1'b0, lat, r, sr);
    checks++;
    if (lat !== 8 || r !== 12'h100) begin
      failures++;
      $display("FAIL hundred: got lat=%0d bcd=%h expected lat=8 bcd=100",
               lat, r);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [11:0] r;
    logic sr;
    logic stable;
    do_conv(8'd99, 1'b0, lat, r, sr);
    checks++;
    if (r !== E99) begin
      failures++;
      $display("FAIL bp_bcd: got %h expected %h", r, E99);
    end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || bcd !== E99) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL bp_stable: got %b expected 1", stable);
    end
    release_out();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release: got %b expected 01",
               {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int g;
    logic [11:0] r;
    logic sr;
    logic ov;
    @(negedge clk);
    bin = 8'd200;
    in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: got %b expected 1", busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || bcd !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset: got %b bcd=%h expected 100 bcd=000",
               {in_ready, out_valid, busy}, bcd);
    end
    ov = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) ov = 1'b1;
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov = 1'b1;
    end
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL mid_no_valid: got %b expected 0", ov);
    end
    do_conv(8'd42, 1'b0, lat, r, sr);
    checks++;
    if (lat !== 8 || r !== E42) begin
      failures++;
      $display("FAIL mid_after: got lat=%0d bcd=%h expected lat=8 bcd=%h",
               lat, r, E42);
    end
    release_out();
  endtask

  task automatic test_sweep();
    int lat;
    logic [11:0] r;
    logic [11:0] e;
    logic sr;
    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), 1'b0, lat, r, sr);
      e = ref_bcd(v);
      checks++;
      if (lat !== 8) begin
        failures++;
        $display("FAIL sweep_lat %0d: got %0d expected 8", v, lat);
      end
      checks++;
      if (r !== e) begin
        failures++;
        $display("FAIL sweep_bcd %0d: got %h expected %h", v, r, e);
      end
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_100();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
